wddl_xor_pipe: RTL and testbench

//  Parametrised, pipelined N-input dual-rail (WDDL) XOR tree for the masked AES datapath (MixColumns/AddRoundKey folding).

---
 rtl/wddl_pkg.sv | 22 ++
 rtl/wddl_prech_reg.sv | 40 ++++
 rtl/wddl_xor2.sv | 18 +
 rtl/wddl_xor_pipe.sv | 115 +++++++++++
 tb/tb_wddl_xor_pipe.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wddl_pkg.sv
// Shared WDDL definitions: phase encoding, null rail code, elaboration helpers.
// Latency: none (package). Backpressure: not applicable.
// Used by every dual-rail cell and register rank in the XOR pipe.
package wddl_pkg;

    localparam logic       WDDL_PRECH = 1'b0;
    localparam logic       WDDL_EVAL  = 1'b1;
    localparam logic [1:0] WDDL_NULL  = 2'b00;   // {p, n} during precharge

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Node count at a tree level: ceil(n / 2^lvl), odd nodes pass through.
    function automatic int level_nodes(input int n, input int lvl);
        return (n + (1 << lvl) - 1) >> lvl;
    endfunction

endpackage

// File: rtl/wddl_prech_reg.sv
// Precharged register rank: master captures at the end of EVAL, slave forces null in PRECH.
// Latency: 2 cycles (EVAL capture -> visible in the next EVAL). Backpressure: none.
// The valid bit follows the same capture and mask rules as the data rails.
module wddl_prech_reg
    import wddl_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ph,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] d_p,
    input  logic [WIDTH-1:0] d_n,
    output logic             vld_out,
    output logic [WIDTH-1:0] q_p,
    output logic [WIDTH-1:0] q_n
);

    logic [WIDTH-1:0] m_p;
    logic [WIDTH-1:0] m_n;
    logic             m_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p   <= '0;
            m_n   <= '0;
            m_vld <= 1'b0;
        end else if (ph == WDDL_EVAL) begin
            m_p   <= d_p;
            m_n   <= d_n;
            m_vld <= vld_in;
        end
    end

    assign q_p     = (ph == WDDL_EVAL) ? m_p : {WIDTH{WDDL_NULL[1]}};
    assign q_n     = (ph == WDDL_EVAL) ? m_n : {WIDTH{WDDL_NULL[0]}};
    assign vld_out = (ph == WDDL_EVAL) & m_vld;

endmodule

// File: rtl/wddl_xor2.sv
// Dual-rail WDDL XOR cell; a null (00) operand yields a null result.
// Latency: combinational. Backpressure: none.
// Bitwise over WIDTH independent rail pairs.
module wddl_xor2 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a_p,
    input  logic [WIDTH-1:0] a_n,
    input  logic [WIDTH-1:0] b_p,
    input  logic [WIDTH-1:0] b_n,
    output logic [WIDTH-1:0] y_p,
    output logic [WIDTH-1:0] y_n
);

    assign y_p = (a_p & b_n) | (a_n & b_p);
    assign y_n = (a_p & b_p) | (a_n & b_n);

endmodule

// File: rtl/wddl_xor_pipe.sv
// Pipelined NUM_IN-operand WDDL XOR tree with a free-running precharge/evaluate phase.
// Latency: 2*ceil(clog2(NUM_IN)/REG_EVERY) cycles. Backpressure: none, one set per 2 cycles.
// Define WDDL_XOR_PIPE_ERR_EN to add the sticky rail-integrity checker on err_out.
module wddl_xor_pipe
    import wddl_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int NUM_IN    = 5,
    parameter int REG_EVERY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] d_p_in,
    input  logic [NUM_IN*WIDTH-1:0] d_n_in,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        d_p_out,
    output logic [WIDTH-1:0]        d_n_out,
    output logic                    err_out
);

    localparam int L  = clog2(NUM_IN);
    localparam int IW = NUM_IN * WIDTH;

    logic          ph;
    logic          xfer;
    logic [IW-1:0] gate_p;
    logic [IW-1:0] gate_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ph <= WDDL_PRECH;
        else        ph <= ~ph;
    end

    assign in_ready = ph;
    assign xfer     = ph & in_valid;
    assign gate_p   = xfer ? d_p_in : '0;
    assign gate_n   = xfer ? d_n_in : '0;

    for (genvar l = 0; l <= L; l++) begin : g_lvl
        localparam int CNT = level_nodes(NUM_IN, l);
        logic [CNT*WIDTH-1:0] eff_p;
        logic [CNT*WIDTH-1:0] eff_n;
        logic                 eff_vld;

        if (l == 0) begin : g_in
            assign eff_p   = gate_p;
            assign eff_n   = gate_n;
            assign eff_vld = xfer;
        end else begin : g_tree
            localparam int PREV = level_nodes(NUM_IN, l - 1);
            logic [CNT*WIDTH-1:0] raw_p;
            logic [CNT*WIDTH-1:0] raw_n;

            for (genvar j = 0; j < CNT; j++) begin : g_node
                if (2 * j + 1 < PREV) begin : g_xor
                    wddl_xor2 #(.WIDTH(WIDTH)) u_xor (
                        .a_p (g_lvl[l-1].eff_p[(2*j)*WIDTH +: WIDTH]),
                        .a_n (g_lvl[l-1].eff_n[(2*j)*WIDTH +: WIDTH]),
                        .b_p (g_lvl[l-1].eff_p[(2*j+1)*WIDTH +: WIDTH]),
                        .b_n (g_lvl[l-1].eff_n[(2*j+1)*WIDTH +: WIDTH]),
                        .y_p (raw_p[j*WIDTH +: WIDTH]),
                        .y_n (raw_n[j*WIDTH +: WIDTH])
                    );
                end else begin : g_pass
                    assign raw_p[j*WIDTH +: WIDTH] = g_lvl[l-1].eff_p[(2*j)*WIDTH +: WIDTH];
                    assign raw_n[j*WIDTH +: WIDTH] = g_lvl[l-1].eff_n[(2*j)*WIDTH +: WIDTH];
                end
            end

            // The root level always closes with a rank so outputs are precharged.
            if ((l % REG_EVERY == 0) || (l == L)) begin : g_rank
                wddl_prech_reg #(.WIDTH(CNT * WIDTH)) u_rank (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .ph      (ph),
                    .vld_in  (g_lvl[l-1].eff_vld),
                    .d_p     (raw_p),
                    .d_n     (raw_n),
                    .vld_out (eff_vld),
                    .q_p     (eff_p),
                    .q_n     (eff_n)
                );
            end else begin : g_comb
                assign eff_p   = raw_p;
                assign eff_n   = raw_n;
                assign eff_vld = g_lvl[l-1].eff_vld;
            end
        end
    end

    assign out_valid = g_lvl[L].eff_vld;
    assign d_p_out   = g_lvl[L].eff_p;
    assign d_n_out   = g_lvl[L].eff_n;

`ifdef WDDL_XOR_PIPE_ERR_EN
    logic err_q;
    logic err_set;

    // Equal rails (00/11) are illegal on an accepted operand; any set rail is illegal in PRECH.
    assign err_set = (xfer && ((~(d_p_in ^ d_n_in)) != '0)) ||
                     ((ph == WDDL_PRECH) && ((d_p_in | d_n_in) != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_q | err_set;
    end

    assign err_out = err_q;
`else
    assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_wddl_xor_pipe.sv
// Directed bench for wddl_xor_pipe: four parameterisations sharing clock, reset and phase.
module tb_wddl_xor_pipe;

`ifdef WDDL_XOR_PIPE_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic       w1_in_valid, w1_in_ready, w1_out_valid, w1_d_p_out, w1_d_n_out, w1_err;
    logic [4:0] w1_d_p, w1_d_n;

    logic        w8_in_valid, w8_in_ready, w8_out_valid, w8_err;
    logic [39:0] w8_d_p, w8_d_n;
    logic [7:0]  w8_d_p_out, w8_d_n_out;

    logic       n2_in_valid, n2_in_ready, n2_out_valid, n2_err;
    logic [7:0] n2_d_p, n2_d_n;
    logic [3:0] n2_d_p_out, n2_d_n_out;

    logic        n9_in_valid, n9_in_ready, n9_out_valid, n9_err;
    logic [35:0] n9_d_p, n9_d_n;
    logic [3:0]  n9_d_p_out, n9_d_n_out;

    wddl_xor_pipe #(.WIDTH(1), .NUM_IN(5), .REG_EVERY(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
        .d_p_in(w1_d_p), .d_n_in(w1_d_n), .out_valid(w1_out_valid),
        .d_p_out(w1_d_p_out), .d_n_out(w1_d_n_out), .err_out(w1_err));

    wddl_xor_pipe #(.WIDTH(8), .NUM_IN(5), .REG_EVERY(1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
        .d_p_in(w8_d_p), .d_n_in(w8_d_n), .out_valid(w8_out_valid),
        .d_p_out(w8_d_p_out), .d_n_out(w8_d_n_out), .err_out(w8_err));

    wddl_xor_pipe #(.WIDTH(4), .NUM_IN(2), .REG_EVERY(1)) u_n2 (
        .clk(clk), .rst_n(rst_n), .in_valid(n2_in_valid), .in_ready(n2_in_ready),
        .d_p_in(n2_d_p), .d_n_in(n2_d_n), .out_valid(n2_out_valid),
        .d_p_out(n2_d_p_out), .d_n_out(n2_d_n_out), .err_out(n2_err));

    wddl_xor_pipe #(.WIDTH(4), .NUM_IN(9), .REG_EVERY(2)) u_n9 (
        .clk(clk), .rst_n(rst_n), .in_valid(n9_in_valid), .in_ready(n9_in_ready),
        .d_p_in(n9_d_p), .d_n_in(n9_d_n), .out_valid(n9_out_valid),
        .d_p_out(n9_d_p_out), .d_n_out(n9_d_n_out), .err_out(n9_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        w1_in_valid = 1'b0; w1_d_p = '0; w1_d_n = '0;
        w8_in_valid = 1'b0; w8_d_p = '0; w8_d_n = '0;
        n2_in_valid = 1'b0; n2_d_p = '0; n2_d_n = '0;
        n9_in_valid = 1'b0; n9_d_p = '0; n9_d_n = '0;
    endtask

    // Leaves the bench 1 ns into an EVAL cycle.
    task automatic sync_eval();
        int n;
        n = 0;
        step();
        while (w1_in_ready !== 1'b1 && n < 4) begin
            step();
            n++;
        end
        checks++;
        if (w1_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL sync_eval: in_ready got %b expected 1", w1_in_ready);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({w1_in_ready, w1_out_valid, w1_d_p_out, w1_d_n_out, w1_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_w1: got %b expected 00000",
                     {w1_in_ready, w1_out_valid, w1_d_p_out, w1_d_n_out, w1_err});
        end
        checks++;
        if ({w8_out_valid, w8_d_p_out, w8_d_n_out, w8_err} !== 18'b0) begin
            errors++;
            $display("FAIL reset_w8: got %h expected 0", {w8_out_valid, w8_d_p_out, w8_d_n_out, w8_err});
        end
        step();
        step();
        rst_n = 1'b1;
        for (int m = 1; m <= 4; m++) begin
            @(negedge clk);
            checks++;
            if (w1_in_ready !== logic'(m % 2 == 0)) begin
                errors++;
                $display("FAIL reset_in_ready cycle %0d: got %b expected %b", m, w1_in_ready, m % 2 == 0);
            end
            step();
        end
    endtask

    task automatic test_single();
        logic exp_v;
        sync_eval();
        w1_in_valid = 1'b1;
        w1_d_p = 5'b01101;   // operands 0..4 = 1,0,1,1,0
        w1_d_n = 5'b10010;
        for (int j = 1; j <= 7; j++) begin
            step();
            if (j == 1) clear_inputs();
            @(negedge clk);
            exp_v = (j == 6);
            checks++;
            if ({w1_out_valid, w1_d_p_out, w1_d_n_out} !== {exp_v, exp_v, 1'b0}) begin
                errors++;
                $display("FAIL single j=%0d: got vld/p/n %b%b%b expected %b%b0",
                         j, w1_out_valid, w1_d_p_out, w1_d_n_out, exp_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops [64][5];
        logic [7:0] exp_x [64];
        logic [7:0] ep, en;
        logic       hit;
        int         idx;
        for (int s = 0; s < 64; s++) begin
            exp_x[s] = 8'h00;
            for (int i = 0; i < 5; i++) begin
                ops[s][i] = 8'($urandom_range(0, 255));
                exp_x[s] = exp_x[s] ^ ops[s][i];
            end
        end
        sync_eval();
        for (int k = 0; k < 136; k++) begin
            if (k > 0) step();
            if (k % 2 == 0 && k / 2 < 64) begin
                w8_in_valid = 1'b1;
                for (int i = 0; i < 5; i++) w8_d_p[i*8 +: 8] = ops[k/2][i];
                w8_d_n = ~w8_d_p;
            end else begin
                clear_inputs();
            end
            @(negedge clk);
            idx = (k - 6) / 2;
            hit = (k >= 6) && (k % 2 == 0) && (idx < 64);
            ep  = hit ? exp_x[idx] : 8'h00;
            en  = hit ? ~exp_x[idx] : 8'h00;
            checks++;
            if ({w8_out_valid, w8_d_p_out, w8_d_n_out} !== {hit, ep, en}) begin
                errors++;
                $display("FAIL b2b k=%0d: got vld %b p %h n %h expected vld %b p %h n %h",
                         k, w8_out_valid, w8_d_p_out, w8_d_n_out, hit, ep, en);
            end
        end
    endtask

    task automatic test_hold_valid();
        logic [7:0] ops [3][5];
        logic [7:0] exp_x [3];
        logic [7:0] ep;
        logic       hit;
        int         seen;
        seen = 0;
        for (int s = 0; s < 3; s++) begin
            exp_x[s] = 8'h00;
            for (int i = 0; i < 5; i++) begin
                ops[s][i] = 8'($urandom_range(0, 255));
                exp_x[s] = exp_x[s] ^ ops[s][i];
            end
        end
        sync_eval();
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) step();
            clear_inputs();
            w8_in_valid = (k <= 5);
            if (k % 2 == 0 && k <= 4) begin
                for (int i = 0; i < 5; i++) w8_d_p[i*8 +: 8] = ops[k/2][i];
                w8_d_n = ~w8_d_p;
            end
            @(negedge clk);
            hit = (k == 6) || (k == 8) || (k == 10);
            ep  = hit ? exp_x[(k-6)/2] : 8'h00;
            if (w8_out_valid === 1'b1) seen++;
            checks++;
            if ({w8_out_valid, w8_d_p_out, w8_d_n_out} !== {hit, ep, hit ? ~ep : 8'h00}) begin
                errors++;
                $display("FAIL hold k=%0d: got vld %b p %h n %h expected vld %b p %h",
                         k, w8_out_valid, w8_d_p_out, w8_d_n_out, hit, ep);
            end
        end
        checks++;
        if (seen != 3) begin
            errors++;
            $display("FAIL hold_count: got %0d results expected 3", seen);
        end
    endtask

    task automatic test_reset_inflight();
        logic [7:0] ops [3][5];
        logic [7:0] x0;
        x0 = 8'h00;
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 5; i++) ops[s][i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 5; i++) x0 = x0 ^ ops[0][i];
        sync_eval();
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) step();
            clear_inputs();
            if (k % 2 == 0 && k <= 4) begin
                w8_in_valid = 1'b1;
                for (int i = 0; i < 5; i++) w8_d_p[i*8 +: 8] = ops[k/2][i];
                w8_d_n = ~w8_d_p;
            end
        end
        checks++;
        if ({w8_out_valid, w8_d_p_out} !== {1'b1, x0}) begin
            errors++;
            $display("FAIL inflight_pre: got vld %b p %h expected vld 1 p %h", w8_out_valid, w8_d_p_out, x0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({w8_in_ready, w8_out_valid, w8_d_p_out, w8_d_n_out} !== 18'b0) begin
            errors++;
            $display("FAIL inflight_reset: got rdy %b vld %b p %h n %h expected all 0",
                     w8_in_ready, w8_out_valid, w8_d_p_out, w8_d_n_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int m = 1; m <= 12; m++) begin
            step();
            @(negedge clk);
            checks++;
            if ({w8_in_ready, w8_out_valid, w8_d_p_out, w8_d_n_out} !== {logic'(m % 2 == 1), 17'b0}) begin
                errors++;
                $display("FAIL inflight_after m=%0d: got rdy %b vld %b p %h n %h expected rdy %b vld 0 p 00 n 00",
                         m, w8_in_ready, w8_out_valid, w8_d_p_out, w8_d_n_out, m % 2 == 1);
            end
        end
    endtask

    task automatic test_err();
        sync_eval();
        w8_in_valid = 1'b1;
        w8_d_p = 40'h00_00_FF_00_00;   // operand 2 carries 11 on every bit
        w8_d_n = 40'hFF_FF_FF_FF_FF;
        step();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (w8_err !== ERR_EXP) begin
            errors++;
            $display("FAIL err_set: got %b expected %b", w8_err, ERR_EXP);
        end
        for (int m = 0; m < 4; m++) step();
        @(negedge clk);
        checks++;
        if (w8_err !== ERR_EXP) begin
            errors++;
            $display("FAIL err_sticky: got %b expected %b", w8_err, ERR_EXP);
        end
        checks++;
        if ({w1_err, n2_err, n9_err} !== 3'b000) begin
            errors++;
            $display("FAIL err_others: got %b expected 000", {w1_err, n2_err, n9_err});
        end
        step();
        rst_n = 1'b0;
        #2;
        checks++;
        if (w8_err !== 1'b0) begin
            errors++;
            $display("FAIL err_reset: got %b expected 0", w8_err);
        end
        rst_n = 1'b1;
        w8_d_p = 40'h1;                // non-null rail in a PRECH cycle
        step();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (w8_err !== ERR_EXP) begin
            errors++;
            $display("FAIL err_prech: got %b expected %b", w8_err, ERR_EXP);
        end
    endtask

    task automatic test_latency();
        logic       h2, h9;
        logic [3:0] e2, e9;
        sync_eval();
        n2_in_valid = 1'b1; n2_d_p = {4'hC, 4'h6}; n2_d_n = ~n2_d_p;
        n9_in_valid = 1'b1;
        n9_d_p = {4'hF, 4'h9, 4'h6, 4'h5, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1};
        n9_d_n = ~n9_d_p;
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) step();
            if (k == 1) clear_inputs();
            if (k == 2) begin
                n2_in_valid = 1'b1; n2_d_p = {4'h5, 4'h3}; n2_d_n = ~n2_d_p;
            end
            if (k == 3) clear_inputs();
            @(negedge clk);
            h2 = (k == 2) || (k == 4);
            e2 = (k == 2) ? 4'hA : ((k == 4) ? 4'h6 : 4'h0);
            h9 = (k == 4);
            e9 = h9 ? 4'h9 : 4'h0;
            checks++;
            if ({n2_out_valid, n2_d_p_out, n2_d_n_out} !== {h2, e2, h2 ? ~e2 : 4'h0}) begin
                errors++;
                $display("FAIL lat_n2 k=%0d: got vld %b p %h n %h expected vld %b p %h",
                         k, n2_out_valid, n2_d_p_out, n2_d_n_out, h2, e2);
            end
            checks++;
            if ({n9_out_valid, n9_d_p_out, n9_d_n_out} !== {h9, e9, h9 ? ~e9 : 4'h0}) begin
                errors++;
                $display("FAIL lat_n9 k=%0d: got vld %b p %h n %h expected vld %b p %h",
                         k, n9_out_valid, n9_d_p_out, n9_d_n_out, h9, e9);
            end
        end
        checks++;
        if ({n2_err, n9_err} !== 2'b00) begin
            errors++;
            $display("FAIL lat_err: got %b expected 00", {n2_err, n9_err});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_valid();
        test_reset_inflight();
        test_err();
        test_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
